// File: rtl/uart_cmd_ctrl.sv
// Command-frame sequencer between uart_rx/uart_tx and vehicle control: frames {HDR, CMD, ARG, CHK},
// XOR checksum, ACK/NAK reply scheduling. Optional link watchdog enabled by `define CMD_WATCHDOG_EN.
module uart_cmd_ctrl #(
  parameter logic [7:0]  HDR_BYTE      = 8'hA5,
  parameter logic [7:0]  ACK_BYTE      = 8'h06,
  parameter logic [7:0]  NAK_BYTE      = 8'h15,
  parameter int unsigned FRAME_TIMEOUT = 8700,
  parameter int unsigned WDOG_CLKS     = 10000000
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  input  logic       i_Tx_Active,
  input  logic       i_Tx_Done,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
  output logic       o_Cmd_Valid,
  output logic [7:0] o_Cmd,
  output logic [7:0] o_Arg,
  output logic [7:0] o_Err_Cnt,
  output logic       o_Stop
);

  typedef enum logic [2:0] {IDLE, GET_CMD, GET_ARG, GET_CHK, RESP, WAIT_TX} state_t;

  localparam int TW = $clog2(FRAME_TIMEOUT + 1);

  state_t        state, state_next;
  logic [TW-1:0] timer;
  logic [7:0]    cmd_q, arg_q;
  logic          in_frame, timeout, chk_good;
  logic          accept, reject, send;

  assign in_frame = (state == GET_CMD) || (state == GET_ARG) || (state == GET_CHK);
  assign timeout  = (timer == TW'(FRAME_TIMEOUT));
  assign chk_good = (i_Rx_Byte == (cmd_q ^ arg_q));

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    send       = 1'b0;
    case (state)
      IDLE:    if (i_Rx_DV && (i_Rx_Byte == HDR_BYTE)) state_next = GET_CMD;
      GET_CMD: if (i_Rx_DV) state_next = GET_ARG; else if (timeout) state_next = IDLE;
      GET_ARG: if (i_Rx_DV) state_next = GET_CHK; else if (timeout) state_next = IDLE;
      GET_CHK: begin
        // A byte arriving on the timeout cycle still completes the frame.
        if (i_Rx_DV) begin
          state_next = RESP;
          accept     = chk_good;
          reject     = !chk_good;
        end else if (timeout) begin
          state_next = IDLE;
        end
      end
      RESP: begin
        if (!i_Tx_Active) begin
          send       = 1'b1;
          state_next = WAIT_TX;
        end
      end
      WAIT_TX: if (i_Tx_Done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      timer       <= '0;
      cmd_q       <= '0;
      arg_q       <= '0;
      o_Tx_DV     <= 1'b0;
      o_Tx_Byte   <= '0;
      o_Cmd_Valid <= 1'b0;
      o_Cmd       <= '0;
      o_Arg       <= '0;
      o_Err_Cnt   <= '0;
    end else begin
      o_Cmd_Valid <= accept;
      o_Tx_DV     <= send;

      if (!in_frame || i_Rx_DV) timer <= '0;
      else if (!timeout)        timer <= timer + 1'b1;

      if ((state == GET_CMD) && i_Rx_DV) cmd_q <= i_Rx_Byte;
      if ((state == GET_ARG) && i_Rx_DV) arg_q <= i_Rx_Byte;

      if (accept) begin
        o_Cmd     <= cmd_q;
        o_Arg     <= arg_q;
        o_Tx_Byte <= ACK_BYTE;
      end
      if (reject) begin
        o_Tx_Byte <= NAK_BYTE;
        if (o_Err_Cnt != 8'hFF) o_Err_Cnt <= o_Err_Cnt + 1'b1;
      end
    end
  end

`ifdef CMD_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CLKS + 1);

  logic [WW-1:0] wdog_cnt;

  // Only accepted frames feed the watchdog; NAKs and timeouts leave it running.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      wdog_cnt <= '0;
      o_Stop   <= 1'b0;
    end else if (accept) begin
      wdog_cnt <= '0;
      o_Stop   <= 1'b0;
    end else if (wdog_cnt == WW'(WDOG_CLKS)) begin
      o_Stop   <= 1'b1;
    end else begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end
`else
  assign o_Stop = 1'b0;
`endif

endmodule
